// File: rtl/piso_tx_pkg.sv
// -----------------------------------------------------------------------------
// piso_tx_pkg
// Shared definitions for the PISO serial transmit controller:
//   - N_DEFAULT / DIV_DEFAULT : default word width and clock cycles per bit
//   - tx_state_e              : controller FSM state encoding
// Configuration macro: PISO_TX_PARITY_EN (adds the PARITY state when defined).
// -----------------------------------------------------------------------------
package piso_tx_pkg;

    localparam int N_DEFAULT   = 8;
    localparam int DIV_DEFAULT = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
`ifdef PISO_TX_PARITY_EN
        ST_DONE   = 2'd2,
        ST_PARITY = 2'd3
`else
        ST_DONE   = 2'd2
`endif
    } tx_state_e;

endpackage : piso_tx_pkg

// File: rtl/piso_core.sv
// -----------------------------------------------------------------------------
// piso_core
// N-bit parallel-in / serial-out shift register. Loads a word, shifts right
// with zero fill when enabled, and exposes its two low bits so the controller
// can register the next serial bit in the same cycle as the shift.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   load        : capture din (takes priority over shift)
//   shift       : shift right by one, zero into the MSB
//   din [N-1:0] : parallel word
//   bit0, bit1  : current register bits 0 and 1
// -----------------------------------------------------------------------------
module piso_core #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] din,
    output logic         bit0,
    output logic         bit1
);

    logic [N-1:0] sreg_q;
    logic [N-1:0] sreg_d;

    // Next shift-register value: load wins over shift, otherwise hold.
    always_comb begin
        sreg_d = sreg_q;
        if (load) begin
            sreg_d = din;
        end else if (shift) begin
            sreg_d = {1'b0, sreg_q[N-1:1]};
        end else begin
            sreg_d = sreg_q;
        end
    end

    // Shift-register state with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign bit0 = sreg_q[0];
    assign bit1 = sreg_q[1];

endmodule : piso_core

// File: rtl/piso_tx_controller.sv
// -----------------------------------------------------------------------------
// piso_tx_controller
// Accepts a parallel word with a VALID/READY handshake and transmits it LSB
// first on SOUT, each bit held DIV clock cycles, followed (optionally) by an
// even-parity bit and a one-cycle DONE pulse.
// Configuration macro: PISO_TX_PARITY_EN -- when defined, an even-parity bit
// is sent for DIV cycles after the data bits.
// Ports:
//   CLK          : clock, all state changes on posedge
//   RESET        : synchronous active-high reset
//   VALID        : requester presents a word on DATAW
//   DATAW [N-1:0]: word to transmit
//   READY        : controller is idle and accepts a word
//   SOUT         : serial data, LSB first
//   FRAME        : high while data/parity bits are on SOUT
//   DONE         : one-cycle pulse after the last bit of a frame
// All outputs are registered.
// -----------------------------------------------------------------------------
module piso_tx_controller
    import piso_tx_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int DIV = DIV_DEFAULT
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         VALID,
    input  logic [N-1:0] DATAW,
    output logic         READY,
    output logic         SOUT,
    output logic         FRAME,
    output logic         DONE
);

    localparam int BW = (N   > 1) ? $clog2(N)   : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    tx_state_e       state_q, state_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic            ready_q, ready_d;
    logic            sout_q, sout_d;
    logic            frame_q, frame_d;
    logic            done_q, done_d;
    logic            core_load_s;
    logic            core_shift_s;
    logic            core_bit0_s;
    logic            core_bit1_s;

`ifdef PISO_TX_PARITY_EN
    logic            parity_q, parity_d;

    function automatic logic even_parity(input logic [N-1:0] word);
        return ^word;
    endfunction
`endif

    piso_core #(
        .N (N)
    ) u_core (
        .clk   (CLK),
        .reset (RESET),
        .load  (core_load_s),
        .shift (core_shift_s),
        .din   (DATAW),
        .bit0  (core_bit0_s),
        .bit1  (core_bit1_s)
    );

    // Next-state, counter sequencing and next registered output values.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        core_load_s  = 1'b0;
        core_shift_s = 1'b0;
`ifdef PISO_TX_PARITY_EN
        parity_d     = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (VALID) begin
                    core_load_s = 1'b1;
                    bit_cnt_d   = '0;
                    div_cnt_d   = '0;
`ifdef PISO_TX_PARITY_EN
                    parity_d    = even_parity(DATAW);
`endif
                    state_d     = ST_SEND;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d    = '0;
                    core_shift_s = 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef PISO_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_DONE;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
`ifdef PISO_TX_PARITY_EN
            ST_PARITY: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    state_d   = ST_DONE;
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                div_cnt_d = '0;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered
        // without adding a cycle of latency.
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
`ifdef PISO_TX_PARITY_EN
        frame_d = (state_d == ST_SEND) || (state_d == ST_PARITY);
`else
        frame_d = (state_d == ST_SEND);
`endif

        // Serial bit that the shift register will present after this edge.
        if (state_d == ST_SEND) begin
            if (core_load_s) begin
                sout_d = DATAW[0];
            end else if (core_shift_s) begin
                sout_d = core_bit1_s;
            end else begin
                sout_d = core_bit0_s;
            end
        end
`ifdef PISO_TX_PARITY_EN
        else if (state_d == ST_PARITY) begin
            sout_d = parity_d;
        end
`endif
        else begin
            sout_d = 1'b0;
        end
    end

    // FSM state, counters and registered outputs; reset beats any handshake.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            ready_q   <= 1'b1;
            sout_q    <= 1'b0;
            frame_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            ready_q   <= ready_d;
            sout_q    <= sout_d;
            frame_q   <= frame_d;
            done_q    <= done_d;
`ifdef PISO_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign READY = ready_q;
    assign SOUT  = sout_q;
    assign FRAME = frame_q;
    assign DONE  = done_q;

endmodule : piso_tx_controller

// File: tb/tb_piso_tx_controller.sv
// -----------------------------------------------------------------------------
// tb_piso_tx_controller
// Directed bench for piso_tx_controller: instance A (N=8, DIV=1) and
// instance B (N=8, DIV=3). Expected serial sequences are written out by hand.
// Honours PISO_TX_PARITY_EN when the bundle is built with it.
// -----------------------------------------------------------------------------
module tb_piso_tx_controller;

    logic       clk;
    logic       a_reset, a_valid, a_ready, a_sout, a_frame, a_done;
    logic [7:0] a_dataw;
    logic       b_reset, b_valid, b_ready, b_sout, b_frame, b_done;
    logic [7:0] b_dataw;

    int total;
    int bad;

    piso_tx_controller #(.N(8), .DIV(1)) dut_a (
        .CLK   (clk),
        .RESET (a_reset),
        .VALID (a_valid),
        .DATAW (a_dataw),
        .READY (a_ready),
        .SOUT  (a_sout),
        .FRAME (a_frame),
        .DONE  (a_done)
    );

    piso_tx_controller #(.N(8), .DIV(3)) dut_b (
        .CLK   (clk),
        .RESET (b_reset),
        .VALID (b_valid),
        .DATAW (b_dataw),
        .READY (b_ready),
        .SOUT  (b_sout),
        .FRAME (b_frame),
        .DONE  (b_done)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Eight data bits of instance A; seq[0] is expected at t0+1.
    task automatic a_bits(input string tag, input logic [0:7] seq);
        for (int k = 0; k < 8; k++) begin
            check({tag, "_sout"},  a_sout,  seq[k]);
            check({tag, "_frame"}, a_frame, 1'b1);
            check({tag, "_ready"}, a_ready, 1'b0);
            tick();
        end
    endtask

    // DONE cycle of instance A.
    task automatic a_done_cycle(input string tag);
        check({tag, "_done"},       a_done,  1'b1);
        check({tag, "_done_frame"}, a_frame, 1'b0);
        check({tag, "_done_sout"},  a_sout,  1'b0);
        check({tag, "_done_ready"}, a_ready, 1'b0);
        tick();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        a_reset = 1'b1; a_valid = 1'b0; a_dataw = 8'h00;
        b_reset = 1'b1; b_valid = 1'b0; b_dataw = 8'h00;
        tick();
        tick();
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Reset state.
        check("rst_a_ready", a_ready, 1'b1);
        check("rst_a_sout",  a_sout,  1'b0);
        check("rst_a_frame", a_frame, 1'b0);
        check("rst_a_done",  a_done,  1'b0);
        check("rst_b_ready", b_ready, 1'b1);
        check("rst_b_done",  b_done,  1'b0);
        tick();
        check("idle_a_ready", a_ready, 1'b1);

        // A5, one-cycle VALID; DATAW changed right after the handshake.
        a_valid = 1'b1; a_dataw = 8'hA5;
        tick();
        a_valid = 1'b0; a_dataw = 8'h5A;
        a_bits("a5", 8'b10100101);
`ifdef PISO_TX_PARITY_EN
        check("a5_par_sout",  a_sout,  1'b0);
        check("a5_par_frame", a_frame, 1'b1);
        tick();
`endif
        a_done_cycle("a5");
        check("a5_after_ready", a_ready, 1'b1);
        check("a5_after_done",  a_done,  1'b0);

        // 07: three ones, parity 1.
        a_valid = 1'b1; a_dataw = 8'h07;
        tick();
        a_valid = 1'b0;
        a_bits("w07", 8'b11100000);
`ifdef PISO_TX_PARITY_EN
        check("w07_par_sout",  a_sout,  1'b1);
        check("w07_par_frame", a_frame, 1'b1);
        tick();
`endif
        a_done_cycle("w07");
        check("w07_after_ready", a_ready, 1'b1);

        // DIV=3, word 01: one for 3 cycles, zero for 21.
        b_valid = 1'b1; b_dataw = 8'h01;
        tick();
        b_valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            check("div3_sout",  b_sout,  (i < 3) ? 1'b1 : 1'b0);
            check("div3_frame", b_frame, 1'b1);
            check("div3_done",  b_done,  1'b0);
            tick();
        end
`ifdef PISO_TX_PARITY_EN
        for (int i = 0; i < 3; i++) begin
            check("div3_par_sout",  b_sout,  1'b1);
            check("div3_par_frame", b_frame, 1'b1);
            tick();
        end
`endif
        check("div3_done_pulse", b_done,  1'b1);
        check("div3_done_frame", b_frame, 1'b0);
        tick();
        check("div3_after_done",  b_done,  1'b0);
        check("div3_after_ready", b_ready, 1'b1);

        // Continuous VALID: 3C then C3; C3 presented during the 3C frame.
        a_valid = 1'b1; a_dataw = 8'h3C;
        tick();
        a_dataw = 8'hC3;
        a_bits("b2b_3c", 8'b00111100);
`ifdef PISO_TX_PARITY_EN
        check("b2b_3c_par", a_sout, 1'b0);
        tick();
`endif
        a_done_cycle("b2b_3c");
        check("b2b_idle_ready", a_ready, 1'b1);
        check("b2b_idle_frame", a_frame, 1'b0);
        check("b2b_idle_done",  a_done,  1'b0);
        tick();
        a_valid = 1'b0;
        a_bits("b2b_c3", 8'b11000011);
`ifdef PISO_TX_PARITY_EN
        check("b2b_c3_par", a_sout, 1'b0);
        tick();
`endif
        a_done_cycle("b2b_c3");
        check("b2b_end_ready", a_ready, 1'b1);

        // Reset wins over a simultaneous handshake.
        a_valid = 1'b1; a_dataw = 8'hFF; a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        check("rstpri_ready", a_ready, 1'b1);
        check("rstpri_frame", a_frame, 1'b0);
        check("rstpri_sout",  a_sout,  1'b0);
        tick();
        a_valid = 1'b0;

        // FF frame aborted by reset while bit 4 is on the line.
        for (int k = 0; k < 4; k++) begin
            check("abort_sout",  a_sout,  1'b1);
            check("abort_frame", a_frame, 1'b1);
            tick();
        end
        check("abort_bit4", a_sout, 1'b1);
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        check("abort_sout0",  a_sout,  1'b0);
        check("abort_frame0", a_frame, 1'b0);
        check("abort_ready",  a_ready, 1'b1);
        check("abort_done",   a_done,  1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort_no_done",  a_done,  1'b0);
            check("abort_idle_rdy", a_ready, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_piso_tx_controller
